// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: funct codes (ALU and HI/LO group),
// the multiply/divide FSM state encoding and the default datapath width.
// Optional build macro SIGNED_MULDIV_EN adds MULT/DIV to the HI/LO group.
package mips_pkg;

  localparam int WIDTH_DEF = 32;

  // ALU-class funct codes
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;

  // HI/LO group funct codes
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  // Instructions that touch HI/LO and therefore must wait for an
  // in-flight iterative operation to finish.
  function automatic logic is_md_op(input logic [5:0] f);
`ifdef SIGNED_MULDIV_EN
    return (f == F_MFHI) || (f == F_MFLO) || (f == F_MULTU) || (f == F_DIVU) ||
           (f == F_MULT) || (f == F_DIV);
`else
    return (f == F_MFHI) || (f == F_MFLO) || (f == F_MULTU) || (f == F_DIVU);
`endif
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage bus between the pipeline and the multiply/divide unit.
// Handshake: the pipeline asserts start with a funct code in Signal; an
// iterative op is taken only when busy is low. While busy, any HI/LO-group
// instruction sees stall high and must be held and re-presented; done
// pulses for one cycle once HI/LO hold the new result.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  import mips_pkg::*;

  logic             start;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] dataOut;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;
  md_state_t        dbg_state;

  modport master (
    output start, Signal, dataA, dataB,
    input  dataOut, hi, lo, busy, done, stall, dbg_state
  );

  modport slave (
    input  start, Signal, dataA, dataB,
    output dataOut, hi, lo, busy, done, stall, dbg_state
  );
endinterface

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {rem,quot} left by one, trial
// subtract the divisor, keep the difference and set the quotient LSB when
// it does not go negative.
module div_restore_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  assign w_shifted = {i_rem, i_quot[WIDTH-1]};
  // The remainder stays below the divisor, so when the trial subtract fits
  // the difference is below the divisor too and WIDTH bits suffice.
  assign w_fits    = (w_shifted >= {1'b0, i_divisor});
  assign w_diff    = w_shifted[WIDTH-1:0] - i_divisor;

  // Select restored or subtracted remainder and the new quotient bit
  always_comb begin
    o_rem  = w_shifted[WIDTH-1:0];
    o_quot = {i_quot[WIDTH-2:0], 1'b0};
    if (w_fits) begin
      o_rem  = w_diff;
      o_quot = {i_quot[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit beside the EX-stage ALU. Owns HI/LO,
// serves MFHI/MFLO through dataOut and stalls the pipeline while an
// iterative MULTU/DIVU runs (one bit per cycle, ITERS cycles).
// Build macro SIGNED_MULDIV_EN: also decode MULT/DIV (sign-magnitude
// wrapper around the same unsigned datapath, same latency).
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITERS = 32
) (
  input logic              clk,
  input logic              reset,
  mul_div_unit_if.slave    bus
);
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  md_state_t          r_state;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_neg_q;   // negate product / quotient at the final write
  logic               r_neg_r;   // negate remainder at the final write

  logic               w_busy;
  logic               w_stall;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quot_next;

`ifdef SIGNED_MULDIV_EN
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction
`endif

  assign w_busy     = (r_state != ST_IDLE);
  assign w_stall    = w_busy && bus.start && is_md_op(bus.Signal);
  assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_quot    (w_quot_next)
  );

  // Accept, iterate and retire MUL/DIV; HI/LO change only on the last edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.Signal == F_MULTU) begin
              r_state  <= ST_MUL;
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, bus.dataA};
              r_mplier <= bus.dataB;
              r_count  <= '0;
              r_neg_q  <= 1'b0;
              r_neg_r  <= 1'b0;
            end else if (bus.Signal == F_DIVU) begin
              r_state   <= ST_DIV;
              r_rem     <= '0;
              r_quot    <= bus.dataA;
              r_divisor <= bus.dataB;
              r_count   <= '0;
              r_neg_q   <= 1'b0;
              r_neg_r   <= 1'b0;
            end
`ifdef SIGNED_MULDIV_EN
            else if (bus.Signal == F_MULT) begin
              r_state  <= ST_MUL;
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, f_mag(bus.dataA)};
              r_mplier <= f_mag(bus.dataB);
              r_count  <= '0;
              r_neg_q  <= bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1];
              r_neg_r  <= 1'b0;
            end else if (bus.Signal == F_DIV) begin
              r_state <= ST_DIV;
              r_rem   <= '0;
              r_count <= '0;
              // Divide by zero runs on the raw operands, like DIVU
              if (bus.dataB == '0) begin
                r_quot    <= bus.dataA;
                r_divisor <= bus.dataB;
                r_neg_q   <= 1'b0;
                r_neg_r   <= 1'b0;
              end else begin
                r_quot    <= f_mag(bus.dataA);
                r_divisor <= f_mag(bus.dataB);
                r_neg_q   <= bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1];
                r_neg_r   <= bus.dataA[WIDTH-1];
              end
            end
`endif
          end
        end
        ST_MUL: begin
          r_acc    <= w_mul_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          if (r_count == LAST) begin
            r_state      <= ST_IDLE;
            r_done       <= 1'b1;
            {r_hi, r_lo} <= r_neg_q ? -w_mul_next : w_mul_next;
          end
        end
        ST_DIV: begin
          r_rem   <= w_rem_next;
          r_quot  <= w_quot_next;
          r_count <= r_count + CW'(1);
          if (r_count == LAST) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_lo    <= r_neg_q ? -w_quot_next : w_quot_next;
            r_hi    <= r_neg_r ? -w_rem_next : w_rem_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // MFHI/MFLO read path into the EX result mux; blanked while stalled
  always_comb begin
    bus.dataOut = '0;
    if (!reset && !w_stall && bus.start) begin
      if (bus.Signal == F_MFHI)      bus.dataOut = r_hi;
      else if (bus.Signal == F_MFLO) bus.dataOut = r_lo;
    end
  end

  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.stall     = w_stall;
  assign bus.dbg_state = r_state;
endmodule
